// File: rtl/mem_bus_arbiter_pkg.sv
// Shared native memory bus definitions.
// Bus widths, arbiter state encoding, default error read data.
package mem_bus_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;
endpackage

// File: rtl/mem_bus_arb_pick.sv
// Winner select for the two-master arbiter.
// Ports: req0/req1 requests, last_gnt previous winner, win chosen master.
module mem_bus_arb_pick #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic win
);

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      req0 && req1:  win = FIXED_PRIO ? 1'b0 : ~last_gnt;
      !req0 && req1: win = 1'b1;
      default:       win = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the native memory bus, atomic transactions.
// Ports: clk, rst (sync, active-high); m0_*/m1_* master sides
// (valid, instr, addr, wdata, wstrb in; ready, rdata out); s_* slave
// side (valid, instr, addr, wdata, wstrb out; ready, rdata in);
// gnt_id, busy status; err_pulse, err_addr timeout report.
// Optional BUSY timeout: define MEM_BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int               FIXED_PRIO     = 0,
  parameter int               TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA     = ERR_RDATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  input  logic              m0_instr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic              m1_instr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic              s_instr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              gnt_id,
  output logic              busy,
  output logic              err_pulse,
  output logic [ADDR_W-1:0] err_addr
);

  arb_state_t        state;
  logic              gnt_q;
  logic              last_gnt;
  logic              win;
  logic              is_busy;
  logic              sel_valid;
  logic              to_hit;
  logic              rsp;
  logic [DATA_W-1:0] rsp_data;

  mem_bus_arb_pick #(
    .FIXED_PRIO(FIXED_PRIO != 0)
  ) u_pick (
    .req0    (m0_valid),
    .req1    (m1_valid),
    .last_gnt(last_gnt),
    .win     (win)
  );

  assign is_busy   = state == ARB_BUSY;
  assign sel_valid = gnt_q ? m1_valid : m0_valid;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0]       to_cnt;
  logic [ADDR_W-1:0] err_addr_q;

  // s_ready on the last allowed cycle completes normally.
  assign to_hit = is_busy && sel_valid && !s_ready
                  && to_cnt == TO_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt     <= '0;
      err_addr_q <= '0;
    end else begin
      if (!is_busy)
        to_cnt <= '0;
      else if (!s_ready)
        to_cnt <= to_cnt + 16'd1;
      if (to_hit)
        err_addr_q <= s_addr;
    end
  end

  assign err_pulse = to_hit;
  assign err_addr  = err_addr_q;
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
  assign to_hit    = 1'b0;
  assign err_pulse = 1'b0;
  assign err_addr  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      gnt_q    <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (m0_valid || m1_valid) begin
            gnt_q    <= win;
            last_gnt <= win;
            state    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // A dropped request aborts without a response.
          if (!sel_valid || s_ready || to_hit)
            state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign busy    = is_busy;
  assign gnt_id  = gnt_q;
  assign s_valid = is_busy && sel_valid && !to_hit;

  assign s_instr = is_busy && (gnt_q ? m1_instr : m0_instr);
  assign s_addr  = !is_busy ? '0 : gnt_q ? m1_addr  : m0_addr;
  assign s_wdata = !is_busy ? '0 : gnt_q ? m1_wdata : m0_wdata;
  assign s_wstrb = !is_busy ? '0 : gnt_q ? m1_wstrb : m0_wstrb;

  assign rsp      = is_busy && sel_valid && (s_ready || to_hit);
  assign rsp_data = to_hit ? ERR_RDATA : s_rdata;

  assign m0_ready = rsp && !gnt_q;
  assign m1_ready = rsp && gnt_q;
  assign m0_rdata = (is_busy && !gnt_q) ? rsp_data : '0;
  assign m1_rdata = (is_busy && gnt_q) ? rsp_data : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: round-robin and fixed-priority
// instances share master stimulus, each with its own latency slave.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] s_rdata;
  int          lat;

  logic        rr_m0_ready, rr_m1_ready, rr_s_valid, rr_s_instr;
  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata;
  logic [3:0]  rr_s_wstrb;
  logic        rr_s_ready, rr_gnt_id, rr_busy, rr_err_pulse;
  logic [31:0] rr_err_addr;

  logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_s_instr;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic [3:0]  fp_s_wstrb;
  logic        fp_s_ready, fp_gnt_id, fp_busy, fp_err_pulse;
  logic [31:0] fp_err_addr;

  int rr_w = 0;
  int fp_w = 0;
  int nerr = 0;
  int nchk = 0;

  // Slave answers on the (lat+1)-th cycle of s_valid.
  assign rr_s_ready = rr_busy && (rr_w == lat);
  assign fp_s_ready = fp_busy && (fp_w == lat);

  always @(posedge clk) begin
    rr_w <= (rr_s_valid && !rr_s_ready) ? rr_w + 1 : 0;
    fp_w <= (fp_s_valid && !fp_s_ready) ? fp_w + 1 : 0;
  end

  mem_bus_arbiter #(
    .FIXED_PRIO(0), .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut_rr (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(rr_m0_ready), .m0_rdata(rr_m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(rr_m1_ready), .m1_rdata(rr_m1_rdata),
    .s_valid(rr_s_valid), .s_instr(rr_s_instr), .s_addr(rr_s_addr),
    .s_wdata(rr_s_wdata), .s_wstrb(rr_s_wstrb),
    .s_ready(rr_s_ready), .s_rdata(s_rdata),
    .gnt_id(rr_gnt_id), .busy(rr_busy),
    .err_pulse(rr_err_pulse), .err_addr(rr_err_addr)
  );

  mem_bus_arbiter #(
    .FIXED_PRIO(1), .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut_fp (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
    .s_valid(fp_s_valid), .s_instr(fp_s_instr), .s_addr(fp_s_addr),
    .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb),
    .s_ready(fp_s_ready), .s_rdata(s_rdata),
    .gnt_id(fp_gnt_id), .busy(fp_busy),
    .err_pulse(fp_err_pulse), .err_addr(fp_err_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_masters();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    lat = 3;
    s_rdata = 32'h0;
    // ---- reset state, then single m0 read with 3 wait cycles
    do_reset();
    #3;
    chk("rst_busy", 32'(rr_busy), 32'd0);
    chk("rst_gnt", 32'(rr_gnt_id), 32'd0);
    chk("rst_svalid", 32'(rr_s_valid), 32'd0);
    chk("rst_saddr", rr_s_addr, 32'd0);
    chk("rst_errpulse", 32'(rr_err_pulse), 32'd0);
    chk("rst_erraddr", rr_err_addr, 32'd0);
    m0_valid = 1; m0_addr = 32'h0000_0100; s_rdata = 32'h1234_5678;
    #3;
    chk("rd_c0_svalid", 32'(rr_s_valid), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      #3;
      chk("rd_svalid", 32'(rr_s_valid), 32'd1);
      chk("rd_saddr", rr_s_addr, 32'h0000_0100);
      chk("rd_m0rdy", 32'(rr_m0_ready), 32'(c == 4));
      chk("rd_m1rdy", 32'(rr_m1_ready), 32'd0);
    end
    chk("rd_m0rdata", rr_m0_rdata, 32'h1234_5678);
    cyc();
    m0_valid = 0;
    #3;
    chk("rd_done_busy", 32'(rr_busy), 32'd0);

    // ---- continuous tie: rr alternates, fp always m0
    do_reset();
    lat = 1;
    m0_valid = 1; m0_addr = 32'h10; m1_valid = 1; m1_addr = 32'h20;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) cyc();
      #3;
      chk("tie_rr_busy", 32'(rr_busy), 32'(c % 3 != 0));
      chk("tie_fp_busy", 32'(fp_busy), 32'(c % 3 != 0));
      if (c % 3 == 2) begin
        chk("tie_rr_gnt", 32'(rr_gnt_id), 32'((c / 3) % 2));
        chk("tie_rr_m0rdy", 32'(rr_m0_ready), 32'((c / 3) % 2 == 0));
        chk("tie_rr_m1rdy", 32'(rr_m1_ready), 32'((c / 3) % 2 == 1));
        chk("tie_fp_m0rdy", 32'(fp_m0_ready), 32'd1);
        chk("tie_fp_m1rdy", 32'(fp_m1_ready), 32'd0);
      end
    end
    cyc();
    m0_valid = 0;
    cyc();
    #3;
    chk("fp_m1_gnt", 32'(fp_gnt_id), 32'd1);
    chk("fp_m1_saddr", fp_s_addr, 32'h20);

    // ---- m1 write, m0 data must stay off the bus
    do_reset();
    lat = 1;
    m1_valid = 1; m1_addr = 32'h0200_0000; m1_wdata = 32'hCAFE_F00D;
    m1_wstrb = 4'b0011; m1_instr = 0;
    m0_addr = 32'h400; m0_wdata = 32'h1111_1111; m0_wstrb = 4'hF;
    m0_instr = 1;
    cyc();
    m0_valid = 1;
    #3;
    chk("wr_gnt", 32'(rr_gnt_id), 32'd1);
    chk("wr_saddr", rr_s_addr, 32'h0200_0000);
    chk("wr_swdata", rr_s_wdata, 32'hCAFE_F00D);
    chk("wr_swstrb", 32'(rr_s_wstrb), 32'h3);
    chk("wr_sinstr", 32'(rr_s_instr), 32'd0);
    cyc();
    #3;
    chk("wr_m1rdy", 32'(rr_m1_ready), 32'd1);
    chk("wr_m0rdy", 32'(rr_m0_ready), 32'd0);
    cyc();
    m1_valid = 0;
    #3;
    chk("wr_idle_swdata", rr_s_wdata, 32'd0);
    chk("wr_idle_svalid", 32'(rr_s_valid), 32'd0);
    cyc();
    #3;
    chk("wr_m0_swdata", rr_s_wdata, 32'h1111_1111);
    chk("wr_m0_sinstr", 32'(rr_s_instr), 32'd1);

    // ---- granted master drops valid mid-transaction
    do_reset();
    lat = 100;
    m0_valid = 1; m0_addr = 32'h500; m1_valid = 1; m1_addr = 32'h600;
    cyc();
    #3;
    chk("drop_c1_svalid", 32'(rr_s_valid), 32'd1);
    cyc();
    m0_valid = 0;
    #3;
    chk("drop_svalid", 32'(rr_s_valid), 32'd0);
    chk("drop_m0rdy", 32'(rr_m0_ready), 32'd0);
    cyc();
    #3;
    chk("drop_idle", 32'(rr_busy), 32'd0);
    chk("drop_idle_m0rdy", 32'(rr_m0_ready), 32'd0);
    cyc();
    #3;
    chk("drop_m1_gnt", 32'(rr_gnt_id), 32'd1);
    chk("drop_m1_saddr", rr_s_addr, 32'h600);
    do_reset();
    #3;
    chk("abort_busy", 32'(rr_busy), 32'd0);
    chk("abort_m1rdy", 32'(rr_m1_ready), 32'd0);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    // ---- timeout, slave never ready
    lat = 1000;
    s_rdata = 32'hA5A5_5A5A;
    m0_valid = 1; m0_addr = 32'h0000_0300;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      #3;
      chk("to_m0rdy", 32'(rr_m0_ready), 32'(c == 8));
      chk("to_err", 32'(rr_err_pulse), 32'(c == 8));
    end
    chk("to_rdata", rr_m0_rdata, 32'hDEAD_BEEF);
    chk("to_svalid", 32'(rr_s_valid), 32'd0);
    cyc();
    m0_valid = 0;
    #3;
    chk("to_err_off", 32'(rr_err_pulse), 32'd0);
    chk("to_erraddr", rr_err_addr, 32'h0000_0300);
    chk("to_idle", 32'(rr_busy), 32'd0);
    // ---- s_ready on the timeout cycle wins
    do_reset();
    lat = 7;
    m0_valid = 1; m0_addr = 32'h0000_0304;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      #3;
      chk("tc_m0rdy", 32'(rr_m0_ready), 32'(c == 8));
      chk("tc_err", 32'(rr_err_pulse), 32'd0);
    end
    chk("tc_rdata", rr_m0_rdata, 32'hA5A5_5A5A);
    cyc();
    m0_valid = 0;
    #3;
    chk("tc_erraddr", rr_err_addr, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
